sys_array_os: RTL and testbench

SYS_ARRAY_OS -- requirements
Module: sys_array_os

---
 rtl/sys_array_os.sv | 157 +++++++++++++++
 tb/tb_sys_array_os.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_os.sv
// sys_array_os: output-stationary systolic matmul mesh with saturating accumulators and row-by-row drain
module sys_array_os #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IN_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic signed [IN_WIDTH-1:0]               in_a [ROWS-1:0],
  input  logic signed [IN_WIDTH-1:0]               in_b [COLS-1:0],
  input  logic                                     in_valid,
  input  logic                                     in_last,
  output logic                                     in_ready,
  output logic signed [ACC_WIDTH-1:0]              out_c [COLS-1:0],
  output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic                                     out_sat,
  output logic                                     out_valid,
  input  logic                                     out_ready
);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS) + 1;
  localparam int SW = ACC_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic sat_q, sat_d, any_sat, take, clr;
  logic signed [IN_WIDTH-1:0] a_src [ROWS];
  logic signed [IN_WIDTH-1:0] b_src [COLS];
  logic av_src [ROWS];
  logic bv_src [COLS];
  logic signed [IN_WIDTH-1:0] a_pe [ROWS][COLS];
  logic signed [IN_WIDTH-1:0] b_pe [ROWS][COLS];
  logic av_pe [ROWS][COLS];
  logic bv_pe [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_pe [ROWS][COLS];
  logic sat_pe [ROWS][COLS];
  assign in_ready = state_q == IDLE || state_q == COMPUTE;
  assign take = in_valid && in_ready;
  assign clr = state_q == DRAIN && out_ready && row_q == RW'(ROWS - 1);
  // Row i sees its A operand i cycles late so diagonals meet in the right PE
  for (genvar i = 0; i < ROWS; i++) begin : g_ska
    if (i == 0) begin : g_d
      assign a_src[i] = in_a[i];
      assign av_src[i] = take;
    end else begin : g_d
      logic signed [IN_WIDTH-1:0] d_q [i];
      logic v_q [i];
      always_ff @(posedge clock) begin
        d_q[0] <= in_a[i];
        v_q[0] <= reset ? 1'b0 : take;
        for (int k = 1; k < i; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= reset ? 1'b0 : v_q[k-1];
        end
      end
      assign a_src[i] = d_q[i-1];
      assign av_src[i] = v_q[i-1];
    end
  end
  for (genvar j = 0; j < COLS; j++) begin : g_skb
    if (j == 0) begin : g_d
      assign b_src[j] = in_b[j];
      assign bv_src[j] = take;
    end else begin : g_d
      logic signed [IN_WIDTH-1:0] d_q [j];
      logic v_q [j];
      always_ff @(posedge clock) begin
        d_q[0] <= in_b[j];
        v_q[0] <= reset ? 1'b0 : take;
        for (int k = 1; k < j; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= reset ? 1'b0 : v_q[k-1];
        end
      end
      assign b_src[j] = d_q[j-1];
      assign bv_src[j] = v_q[j-1];
    end
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_r
    for (genvar j = 0; j < COLS; j++) begin : g_c
      logic signed [IN_WIDTH-1:0] a_in, b_in, a_q, b_q;
      logic av_in, bv_in, av_q, bv_q, ovf;
      logic signed [2*IN_WIDTH-1:0] prod;
      logic signed [SW-1:0] sum;
      logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
      if (j == 0) begin : g_a
        assign a_in = a_src[i];
        assign av_in = av_src[i];
      end else begin : g_a
        assign a_in = a_pe[i][j-1];
        assign av_in = av_pe[i][j-1];
      end
      if (i == 0) begin : g_b
        assign b_in = b_src[j];
        assign bv_in = bv_src[j];
      end else begin : g_b
        assign b_in = b_pe[i-1][j];
        assign bv_in = bv_pe[i-1][j];
      end
      assign prod = a_q * b_q;
      assign sum = SW'(acc_q) + SW'(prod);
      // One guard bit suffices: sign disagreement with the next bit means overflow
      assign ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
      assign acc_d = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
      always_ff @(posedge clock) begin
        a_q <= a_in;
        b_q <= b_in;
        av_q <= reset ? 1'b0 : av_in;
        bv_q <= reset ? 1'b0 : bv_in;
        acc_q <= (reset || clr) ? '0 : (av_q && bv_q) ? acc_d : acc_q;
      end
      assign a_pe[i][j] = a_q;
      assign b_pe[i][j] = b_q;
      assign av_pe[i][j] = av_q;
      assign bv_pe[i][j] = bv_q;
      assign acc_pe[i][j] = acc_q;
      assign sat_pe[i][j] = av_q && bv_q && ovf;
    end
  end
  always_comb begin
    any_sat = 1'b0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        any_sat = any_sat | sat_pe[i][j];
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    sat_d = sat_q | any_sat;
    cnt_d = state_q == FLUSH ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE:    state_d = take ? (in_last ? FLUSH : COMPUTE) : IDLE;
      COMPUTE: state_d = (take && in_last) ? FLUSH : COMPUTE;
      FLUSH:   state_d = cnt_q == FW'(ROWS + COLS - 2) ? DRAIN : FLUSH;
      DRAIN: begin
        row_d = clr ? '0 : out_ready ? row_q + 1'b1 : row_q;
        state_d = clr ? IDLE : DRAIN;
        sat_d = clr ? 1'b0 : sat_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    state_q <= reset ? IDLE : state_d;
    cnt_q <= reset ? '0 : cnt_d;
    row_q <= reset ? '0 : row_d;
    sat_q <= reset ? 1'b0 : sat_d;
  end
  always_comb begin
    for (int j = 0; j < COLS; j++) out_c[j] = acc_pe[row_q][j];
  end
  assign out_row = row_q;
  assign out_sat = sat_q;
  assign out_valid = state_q == DRAIN;
endmodule

// File: tb/tb_sys_array_os.sv
// tb_sys_array_os: scoreboard bench for the 2x2 output-stationary mesh
module tb_sys_array_os;
  localparam int R = 2, C = 2, IW = 8, AW = 16;
  logic clock = 1'b0, reset = 1'b1;
  logic signed [IW-1:0] in_a [R-1:0];
  logic signed [IW-1:0] in_b [C-1:0];
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_sat, out_valid;
  logic [0:0] out_row;
  logic signed [AW-1:0] out_c [C-1:0];
  typedef struct { int c0; int c1; int row; bit sat; } exp_t;
  exp_t sb [$];
  int m [R][C];
  bit m_sat;
  int errors = 0, checks = 0;

  sys_array_os #(.ROWS(R), .COLS(C), .IN_WIDTH(IW), .ACC_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_c(out_c), .out_row(out_row),
    .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) m[i][j] = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_beat(int a0, int a1, int b0, int b1);
    int a [R];
    int b [C];
    a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        m[i][j] = m[i][j] + a[i] * b[j];
        if (m[i][j] > 32767) begin m[i][j] = 32767; m_sat = 1'b1; end
        if (m[i][j] < -32768) begin m[i][j] = -32768; m_sat = 1'b1; end
      end
  endtask

  task automatic expect_job();
    for (int i = 0; i < R; i++) sb.push_back('{m[i][0], m[i][1], i, m_sat});
    model_clear();
  endtask

  task automatic send(int a0, int a1, int b0, int b1, bit last, int gap);
    int n = 0;
    in_a[0] = IW'(a0); in_a[1] = IW'(a1);
    in_b[0] = IW'(b0); in_b[1] = IW'(b1);
    in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(a0, a1, b0, b1);
    for (int g = 0; g < gap; g++) begin
      in_last = 1'b1;
      tick();
    end
    in_last = 1'b0;
  endtask

  task automatic collect(int lat, int stall);
    exp_t e;
    int n;
    while (sb.size() > 0) begin
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_wait: out_valid=%b required 1 within 40 cycles", out_valid);
      end
      if (lat >= 0) begin
        checks++;
        if (n !== lat) begin
          errors++;
          $display("FAIL latency: got %0d cycles required %0d", n, lat);
        end
      end
      lat = -1;
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++;
        if (out_c[0] !== e.c0 || out_c[1] !== e.c1 || out_row !== 1'(e.row) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: c=[%0d,%0d] row=%0d v=%b rdy=%b required c=[%0d,%0d] row=%0d v=1 rdy=0",
                   out_c[0], out_c[1], out_row, out_valid, in_ready, e.c0, e.c1, e.row);
        end
      end
      stall = 0;
      checks++;
      if (out_c[0] !== e.c0 || out_c[1] !== e.c1) begin
        errors++;
        $display("FAIL row_data: row %0d got [%0d,%0d] required [%0d,%0d]", e.row, out_c[0], out_c[1], e.c0, e.c1);
      end
      checks++;
      if (out_row !== 1'(e.row)) begin
        errors++;
        $display("FAIL row_index: got %0d required %0d", out_row, e.row);
      end
      checks++;
      if (out_sat !== e.sat) begin
        errors++;
        $display("FAIL out_sat: row %0d got %b required %b", e.row, out_sat, e.sat);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_row !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%b rdy=%b row=%0d sat=%b required v=0 rdy=1 row=0 sat=0",
               out_valid, in_ready, out_row, out_sat);
    end
    model_clear();
  endtask

  task automatic test_basic();
    send(1, 3, 5, 6, 1'b0, 0);
    send(2, 4, 7, 8, 1'b1, 0);
    expect_job();
    collect(R + C - 1, 0);
  endtask

  task automatic test_saturation();
    send(127, -128, 127, 127, 1'b0, 0);
    send(127, -128, 127, 127, 1'b0, 0);
    send(127, -128, 127, 127, 1'b1, 0);
    expect_job();
    collect(-1, 0);
  endtask

  task automatic test_backpressure();
    send(1, 3, 5, 6, 1'b0, 0);
    send(2, 4, 7, 8, 1'b1, 0);
    expect_job();
    collect(-1, 5);
  endtask

  task automatic test_bubbles();
    send(1, 3, 5, 6, 1'b0, 3);
    send(2, 4, 7, 8, 1'b1, 0);
    expect_job();
    collect(R + C - 1, 0);
  endtask

  task automatic test_reset_mid_flush();
    send(1, 3, 5, 6, 1'b0, 0);
    send(2, 4, 7, 8, 1'b1, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sat !== 1'b0 || out_row !== 1'b0) begin
      errors++;
      $display("FAIL flush_reset: v=%b rdy=%b sat=%b row=%0d required v=0 rdy=1 sat=0 row=0",
               out_valid, in_ready, out_sat, out_row);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_reset_idle: out_valid=%b required 0", out_valid);
    end
    send(2, -1, 3, 4, 1'b1, 0);
    expect_job();
    collect(R + C - 1, 0);
  endtask

  task automatic test_back_to_back();
    send(127, -128, 127, 127, 1'b0, 0);
    send(127, -128, 127, 127, 1'b0, 0);
    send(127, -128, 127, 127, 1'b1, 0);
    expect_job();
    collect(-1, 0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b required 1 right after final transfer", in_ready);
    end
    send(1, 3, 5, 6, 1'b0, 0);
    send(2, 4, 7, 8, 1'b1, 0);
    expect_job();
    collect(R + C - 1, 0);
  endtask

  initial begin
    in_a[0] = '0; in_a[1] = '0; in_b[0] = '0; in_b[1] = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_mid_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
